// File: rtl/mudi_issue_ctrl.sv
// In-order issue controller for the multiply/divide unit: buffers E-stage HI/LO requests,
// pulses start per op, waits out the unit's busy window and serves mfhi/mflo as tagged responses.
module mudi_issue_ctrl #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned WATCHDOG   = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic [4:0]  req_tag,
  output logic        mudi_start,
  output logic [2:0]  mudi_op,
  output logic [31:0] mudi_src1,
  output logic [31:0] mudi_src2,
  input  logic        mudi_busy,
  input  logic [31:0] mudi_hi,
  input  logic [31:0] mudi_lo,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_tag,
  output logic        div0,
  output logic        timeout
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned WW = $clog2(WATCHDOG + 1);

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MFHI  = 3'd6,
    OP_MFLO  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  typedef struct packed {
    op_e         op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  tag;
  } req_t;

  req_t          r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  state_e        r_state;
  logic [WW-1:0] r_wd;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_read;
  logic w_drop;
  logic w_issue;
  req_t w_head;

  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign req_ready = !w_full;
  assign w_push    = req_valid && !w_full;
  assign w_head    = r_mem[r_rd_ptr];
  assign w_pop     = (r_state == S_IDLE) && !w_empty && !mudi_busy;

  // A popped entry resolves to exactly one of: issue, read response, or divide-by-zero drop.
  always_comb begin
    w_read  = 1'b0;
    w_drop  = 1'b0;
    w_issue = 1'b0;
    if (w_pop) begin
      if (w_head.op == OP_MFHI || w_head.op == OP_MFLO) begin
        w_read = 1'b1;
      end else if ((w_head.op == OP_DIV || w_head.op == OP_DIVU) && (w_head.src2 == '0)) begin
        w_drop = 1'b1;
      end else begin
        w_issue = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{op: op_e'(req_op), src1: req_src1, src2: req_src2, tag: req_tag};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_wd       <= '0;
      mudi_start <= 1'b0;
      mudi_op    <= '0;
      mudi_src1  <= '0;
      mudi_src2  <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_tag    <= '0;
      div0       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      mudi_start <= 1'b0;
      div0       <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            mudi_start <= 1'b1;
            mudi_op    <= w_head.op;
            mudi_src1  <= w_head.src1;
            mudi_src2  <= w_head.src2;
            r_state    <= S_ISSUE;
          end else if (w_read) begin
            rsp_valid <= 1'b1;
            rsp_data  <= (w_head.op == OP_MFHI) ? mudi_hi : mudi_lo;
            rsp_tag   <= w_head.tag;
            r_state   <= S_RESP;
          end else if (w_drop) begin
            div0 <= 1'b1;
          end
        end
        S_ISSUE: begin
          r_wd    <= '0;
          r_state <= (mudi_op == OP_MTHI || mudi_op == OP_MTLO) ? S_IDLE : S_WAIT;
        end
        S_WAIT: begin
          if (!mudi_busy) begin
            r_wd    <= '0;
            r_state <= S_IDLE;
          end else if (r_wd == WW'(WATCHDOG - 1)) begin
            r_wd    <= '0;
            timeout <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
